// File: rtl/pipelined_addsub.sv
// ---------------------------------------------------------------------------------------------
// pipelined_addsub
//
// Pipelined carry-chain adder/subtractor for the 32-bit RISC ALU. A WIDTH-bit add is cut into
// STAGES equal slices of CHUNK bits. Stage k resolves slice k and hands its carry to stage k+1,
// so each cycle's critical path is only a CHUNK-bit add. The last stage is the output register.
//
// Subtraction is performed as A + ~B + ~c_in, which makes c_out a "no borrow" flag.
//
// Handshake: valid/ready on both sides. Stage k advances when it is empty or stage k+1
// advances, so bubbles collapse while the output is stalled. in_ready depends only on the
// stage valid bits and out_ready, never on in_valid.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand set presented
//   in_ready   out  an operand set can be accepted this cycle
//   a, b       in   operands (WIDTH bits)
//   c_in       in   carry-in (borrow-in when sub=1)
//   sub        in   0: a+b+c_in, 1: a-b-c_in
//   out_valid  out  output register holds a result
//   out_ready  in   consumer accepts the result this cycle
//   sum        out  result (WIDTH bits)
//   c_out      out  carry out of the MSB (for sub: 1 = no borrow)
//   overflow   out  signed two's-complement overflow
//   zero       out  sum == 0
// ---------------------------------------------------------------------------------------------
module pipelined_addsub #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned CHUNK = WIDTH / STAGES;

    if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_param_check
        $error("pipelined_addsub: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
    end

    // -----------------------------------------------------------------------------------------
    // Per-stage state
    // -----------------------------------------------------------------------------------------
    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] carry_q, carry_d;
    logic [STAGES-1:0] a_msb_q, a_msb_d;
    logic [STAGES-1:0] b_msb_q, b_msb_d;

    // res_q[k] holds result slices 0..k; higher bits are still zero.
    logic [WIDTH-1:0]  res_q [STAGES];
    logic [WIDTH-1:0]  res_d [STAGES];

    // Unconsumed operand bits, pre-shifted so the next stage always works on bits [CHUNK-1:0].
    logic [WIDTH-1:0]  opa_q [STAGES];
    logic [WIDTH-1:0]  opa_d [STAGES];
    logic [WIDTH-1:0]  opb_q [STAGES];
    logic [WIDTH-1:0]  opb_d [STAGES];

    // -----------------------------------------------------------------------------------------
    // Per-stage inputs: stage 0 takes the ports, stage k takes stage k-1's registers
    // -----------------------------------------------------------------------------------------
    logic [WIDTH-1:0]  stg_a   [STAGES];
    logic [WIDTH-1:0]  stg_b   [STAGES];
    logic [WIDTH-1:0]  stg_res [STAGES];
    logic [CHUNK:0]    stg_sum [STAGES];
    logic [STAGES-1:0] stg_cin;
    logic [STAGES-1:0] stg_amsb;
    logic [STAGES-1:0] stg_bmsb;
    logic [STAGES-1:0] stg_load;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage_in
        if (k == 0) begin : g_first
            assign stg_a[k]    = a;
            assign stg_b[k]    = sub ? ~b : b;
            // Borrow-in becomes an inverted carry-in.
            assign stg_cin[k]  = c_in ^ sub;
            assign stg_res[k]  = '0;
            assign stg_amsb[k] = a[WIDTH-1];
            assign stg_bmsb[k] = b[WIDTH-1] ^ sub;
            assign stg_load[k] = in_valid;
        end else begin : g_rest
            assign stg_a[k]    = opa_q[k-1];
            assign stg_b[k]    = opb_q[k-1];
            assign stg_cin[k]  = carry_q[k-1];
            assign stg_res[k]  = res_q[k-1];
            assign stg_amsb[k] = a_msb_q[k-1];
            assign stg_bmsb[k] = b_msb_q[k-1];
            assign stg_load[k] = valid_q[k-1];
        end

        // One CHUNK-bit slice add plus incoming carry; MSB of the result is the slice carry.
        assign stg_sum[k] = {1'b0, stg_a[k][CHUNK-1:0]}
                          + {1'b0, stg_b[k][CHUNK-1:0]}
                          + (CHUNK + 1)'(stg_cin[k]);
    end

    // -----------------------------------------------------------------------------------------
    // Advance chain: stage k moves when it is empty or its successor moves
    // -----------------------------------------------------------------------------------------
    logic [STAGES-1:0] adv;

    always_comb begin
        adv = '0;
        adv[STAGES-1] = ~valid_q[STAGES-1] | out_ready;
        for (int k = int'(STAGES) - 2; k >= 0; k--) begin
            adv[k] = ~valid_q[k] | adv[k+1];
        end
    end

    // -----------------------------------------------------------------------------------------
    // Next-state
    // -----------------------------------------------------------------------------------------
    always_comb begin
        valid_d = valid_q;
        carry_d = carry_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        res_d   = res_q;
        opa_d   = opa_q;
        opb_d   = opb_q;

        for (int k = 0; k < STAGES; k++) begin
            if (adv[k]) begin
                valid_d[k] = stg_load[k];
                // Data only moves with a real transaction; a bubble leaves the payload untouched.
                if (stg_load[k]) begin
                    res_d[k]                    = stg_res[k];
                    res_d[k][k*CHUNK +: CHUNK]  = stg_sum[k][CHUNK-1:0];
                    carry_d[k]                  = stg_sum[k][CHUNK];
                    opa_d[k]                    = stg_a[k] >> CHUNK;
                    opb_d[k]                    = stg_b[k] >> CHUNK;
                    a_msb_d[k]                  = stg_amsb[k];
                    b_msb_d[k]                  = stg_bmsb[k];
                end
            end
        end
    end

    // -----------------------------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            carry_q <= '0;
            a_msb_q <= '0;
            b_msb_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                res_q[k] <= '0;
                opa_q[k] <= '0;
                opb_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            res_q   <= res_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Outputs, all taken from the last stage
    // -----------------------------------------------------------------------------------------
    assign in_ready  = adv[0];
    assign out_valid = valid_q[STAGES-1];
    assign sum       = res_q[STAGES-1];
    assign c_out     = carry_q[STAGES-1];
    // Operands of equal sign producing a result of the other sign. All-zero after reset.
    assign overflow  = (a_msb_q[STAGES-1] == b_msb_q[STAGES-1])
                     & (sum[WIDTH-1] != a_msb_q[STAGES-1]);
    assign zero      = ~|sum;

endmodule
